mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single synchronous unified memory between the multicycle CPU core and the host client port (program loader / debug reads-writes).
- Sequences each access as a grant cycle followed by a response cycle.
- Generates the CPU clock-enable stall while the CPU waits for memory.
- Sits between core, host link and memory macro. The memory has a 1-cycle synchronous read latency.

Parameters:
- ADDR_W, 32, address width for all three ports.
- DATA_W, 32, data width for all three ports.
- HOST_MAX_STREAK, 4, max consecutive host grants while cpu_req is pending before the CPU must be granted (range 1..15).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- cpu_req  in  1  CPU access request; held until cpu_ready
- cpu_we  in  1  CPU write (1) / read (0)
- cpu_addr  in  ADDR_W  CPU byte address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  CPU read data, valid when cpu_ready
- cpu_ready  out  1  one-cycle completion pulse to CPU
- cpu_clk_en  out  1  CPU clock enable; low while a CPU request is outstanding and not completing
- host_req  in  1  host access request; held until host_ack
- host_we  in  1  host write / read
- host_addr  in  ADDR_W  host byte address
- host_wdata  in  DATA_W  host write data
- host_rdata  out  DATA_W  host read data, valid when host_ack
- host_ack  out  1  one-cycle completion pulse to host
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en with mem_we=0

Behaviour:
- Reset:
  - State is IDLE; streak counter is 0.
  - All outputs are 0, except cpu_clk_en=1.
  - cpu_rdata and host_rdata hold 0 until their first read completes.
- States: IDLE, CPU_RSP, HOST_RSP.
- IDLE:
  - Grant host if host_req and (streak < HOST_MAX_STREAK or !cpu_req).
  - Otherwise grant CPU if cpu_req.
  - Otherwise stay in IDLE with mem_en=0.
  - The grant is combinational in the same cycle: mem_en=1, and mem_we/addr/wdata are muxed from the winner.
  - Next state is the winner's RSP state.
- CPU_RSP:
  - cpu_ready=1 for exactly this cycle.
  - cpu_rdata is loaded from mem_rdata if the access was a read, else it holds.
  - Next state is IDLE; mem_en=0.
- HOST_RSP: same as CPU_RSP, using host_ack and host_rdata.
- Throughput: each access occupies 2 cycles; a new grant is possible on the cycle after ready/ack.
- Streak counter:
  - Increments on each host grant made while cpu_req=1; saturates at HOST_MAX_STREAK.
  - Clears on any CPU grant, and on any cycle in IDLE with cpu_req=0.
- cpu_clk_en:
  - Equals !cpu_req | cpu_ready.
  - The core advances only on the ready cycle of its access, or when it has no request.
- Simultaneous requests with streak below the limit: host wins.
- Handshake: a requester deasserting req before ready/ack is a protocol violation; the behaviour is undefined, with no recovery required.
- Write-data capture: latched by the memory at the grant cycle; later changes to wdata have no effect.
- Async reset mid-access:
  - Returns to IDLE immediately and drops ready/ack; the outstanding access is abandoned.
  - A write already strobed at the grant cycle is not undone.

Optional Feature:
- Macro: ARB_STATS_EN.
- When defined, adds 32-bit outputs stat_cpu_grants, stat_host_grants and stat_cpu_stall_cycles.
  - stat_cpu_stall_cycles increments on every cycle with cpu_clk_en=0.
  - All three counters reset to 0, wrap at 2^32, and increment on the grant cycle (stall counter: per stalled cycle).
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- CPU read only: cpu_req=1, addr=0x10, memory preloaded 0xDEADBEEF.
  - mem_en at cycle 0; cpu_ready and cpu_rdata=0xDEADBEEF at cycle 1.
  - cpu_clk_en=0 at cycle 0 and 1 at cycle 1.
- Host write then CPU read of same address: host writes 0x1234 to 0x20, then CPU reads 0x20 -> host_ack at cycle 1, CPU grant at cycle 2, cpu_rdata=0x1234 at cycle 3.
- Contention, HOST_MAX_STREAK=4, host_req and cpu_req both held high from cycle 0:
  - Host is granted at cycles 0, 2, 4 and 6.
  - CPU is granted at cycle 8; host is granted again at cycle 10.
- Idle: no requests for 10 cycles -> mem_en=0, cpu_clk_en=1 and ready/ack=0 throughout.
- Reset mid-access: assert rst during CPU_RSP -> cpu_ready=0 immediately, state IDLE, cpu_clk_en=1, streak 0.
- With ARB_STATS_EN defined, run the contention scenario for 20 cycles:
  - stat_host_grants=8 and stat_cpu_grants=2.
  - stat_cpu_stall_cycles equals the count of cpu_clk_en=0 cycles.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one synchronous unified memory (1-cycle read latency) between the
//   multicycle CPU core and the host client port (program loader / debug).
//   Every access takes two cycles: a grant cycle, where the memory is strobed
//   with the winner's command, and a response cycle, where the winner gets
//   its one-cycle ready/ack pulse together with the read data.
//   The host wins simultaneous requests until it has taken HOST_MAX_STREAK
//   consecutive grants while the CPU was waiting. After that the CPU is
//   guaranteed the next slot.
//   cpu_clk_en stalls the core while its request is outstanding.
//   Optional build macro: ARB_STATS_EN adds the 32-bit grant and stall
//   counters stat_cpu_grants, stat_host_grants and stat_cpu_stall_cycles.
//
// Handshake (both client ports):
//   A client raises req together with we/addr/wdata. It holds req until it
//   sees its one-cycle ready/ack pulse. The memory captures wdata on the grant
//   cycle, so later changes to wdata have no effect. Read data is valid on the
//   ready/ack cycle and is held afterwards until the next read from that port.
//   A client may raise a new request on the cycle after ready/ack.
//   Dropping req before ready/ack is not supported.
//
// Debug: dbg_state shows the FSM state, with IDLE=0, CPU_RSP=1 and HOST_RSP=2.
//   dbg_streak shows the host streak counter.
module mem_port_arbiter #(
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 32,
   parameter int HOST_MAX_STREAK = 4
) (
   input  logic              clk,
   input  logic              rst,
   // CPU core port
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ready,
   output logic              cpu_clk_en,
   // host client port
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic [DATA_W-1:0] host_rdata,
   output logic              host_ack,
   // memory macro port
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   // debug visibility
   output logic [1:0]        dbg_state,
   output logic [3:0]        dbg_streak
`ifdef ARB_STATS_EN
   ,
   output logic [31:0]       stat_cpu_grants,
   output logic [31:0]       stat_host_grants,
   output logic [31:0]       stat_cpu_stall_cycles
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_CPU_RSP  = 2'd1,
      ST_HOST_RSP = 2'd2
   } state_t;

   // HOST_MAX_STREAK is limited to 1..15, so a 4-bit counter always fits it.
   localparam logic [3:0] MAX_STREAK = 4'(HOST_MAX_STREAK);

   state_t            r_state;
   state_t            w_next_state;
   logic [3:0]        r_streak;
   logic              r_acc_rd;      // latched access in flight is a read
   logic [DATA_W-1:0] r_cpu_rdata;
   logic [DATA_W-1:0] r_host_rdata;

   logic              w_grant_cpu;
   logic              w_grant_host;
   logic              w_cpu_ready;
   logic              w_host_ack;
   logic              w_host_allowed;

   // The host may take the slot while under its streak limit or when the CPU
   // is not asking at all.
   assign w_host_allowed = (r_streak < MAX_STREAK) || !cpu_req;

   // Next state, same-cycle grant and memory command mux.
   // The outputs are forced to their reset values while rst is high.
   always_comb begin
      w_next_state = r_state;
      w_grant_cpu  = 1'b0;
      w_grant_host = 1'b0;
      w_cpu_ready  = 1'b0;
      w_host_ack   = 1'b0;
      mem_en       = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      if (!rst) begin
         case (r_state)
            ST_IDLE: begin
               if (host_req && w_host_allowed) begin
                  w_grant_host = 1'b1;
                  mem_en       = 1'b1;
                  mem_we       = host_we;
                  mem_addr     = host_addr;
                  mem_wdata    = host_wdata;
                  w_next_state = ST_HOST_RSP;
               end else if (cpu_req) begin
                  w_grant_cpu  = 1'b1;
                  mem_en       = 1'b1;
                  mem_we       = cpu_we;
                  mem_addr     = cpu_addr;
                  mem_wdata    = cpu_wdata;
                  w_next_state = ST_CPU_RSP;
               end
            end
            ST_CPU_RSP: begin
               w_cpu_ready  = 1'b1;
               w_next_state = ST_IDLE;
            end
            ST_HOST_RSP: begin
               w_host_ack   = 1'b1;
               w_next_state = ST_IDLE;
            end
            default: begin
               w_next_state = ST_IDLE;
            end
         endcase
      end
   end

   // State register. An asynchronous reset abandons any access in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next_state;
   end

   // Host streak counter.
   // It counts host grants taken while the CPU waits and saturates at the
   // limit. It clears on a CPU grant or whenever the CPU is idle in IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_streak <= 4'd0;
      end else if (r_state == ST_IDLE) begin
         if (!cpu_req || w_grant_cpu)
            r_streak <= 4'd0;
         else if (w_grant_host && (r_streak != MAX_STREAK))
            r_streak <= r_streak + 4'd1;
      end
   end

   // Remember whether the granted access is a read so that only reads load
   // the response data registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_acc_rd <= 1'b0;
      else if (w_grant_cpu || w_grant_host)
         r_acc_rd <= !mem_we;
   end

   // Read data holding registers. They load on the response cycle of a read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cpu_rdata  <= '0;
         r_host_rdata <= '0;
      end else begin
         if (w_cpu_ready && r_acc_rd)  r_cpu_rdata  <= mem_rdata;
         if (w_host_ack && r_acc_rd)   r_host_rdata <= mem_rdata;
      end
   end

   // On a read response, the memory output passes straight through.
   // This lets the data arrive on the same cycle as ready/ack.
   assign cpu_rdata  = (w_cpu_ready && r_acc_rd) ? mem_rdata : r_cpu_rdata;
   assign host_rdata = (w_host_ack && r_acc_rd)  ? mem_rdata : r_host_rdata;
   assign cpu_ready  = w_cpu_ready;
   assign host_ack   = w_host_ack;

   // The core advances when it has no request or on its ready cycle.
   // Under reset it is left free-running.
   assign cpu_clk_en = rst || !cpu_req || w_cpu_ready;

   assign dbg_state  = r_state;
   assign dbg_streak = r_streak;

`ifdef ARB_STATS_EN
   logic [31:0] r_stat_cpu;
   logic [31:0] r_stat_host;
   logic [31:0] r_stat_stall;

   // Free-running, wrapping statistics.
   // The grant counters step on the grant cycle. The stall counter steps on
   // every cycle the core is held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stat_cpu   <= 32'd0;
         r_stat_host  <= 32'd0;
         r_stat_stall <= 32'd0;
      end else begin
         if (w_grant_cpu)  r_stat_cpu   <= r_stat_cpu + 32'd1;
         if (w_grant_host) r_stat_host  <= r_stat_host + 32'd1;
         if (!cpu_clk_en)  r_stat_stall <= r_stat_stall + 32'd1;
      end
   end

   assign stat_cpu_grants       = r_stat_cpu;
   assign stat_host_grants      = r_stat_host;
   assign stat_cpu_stall_cycles = r_stat_stall;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter.
// A behavioural 1-cycle-latency memory is attached to the memory port.
// Inputs are driven on the falling edge. Outputs are sampled 1 ns later,
// which is well away from the rising edge.
module tb_mem_port_arbiter;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cpu_req = 1'b0, cpu_we = 1'b0;
   logic [ADDR_W-1:0] cpu_addr = '0;
   logic [DATA_W-1:0] cpu_wdata = '0;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_ready, cpu_clk_en;
   logic              host_req = 1'b0, host_we = 1'b0;
   logic [ADDR_W-1:0] host_addr = '0;
   logic [DATA_W-1:0] host_wdata = '0;
   logic [DATA_W-1:0] host_rdata;
   logic              host_ack;
   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic [1:0]        dbg_state;
   logic [3:0]        dbg_streak;
`ifdef ARB_STATS_EN
   logic [31:0]       stat_cpu_grants, stat_host_grants, stat_cpu_stall_cycles;
`endif

   int checks = 0;
   int errors = 0;

   // {mem_en, mem_we, cpu_ready, host_ack, cpu_clk_en}
   logic [4:0] ctrl;
   assign ctrl = {mem_en, mem_we, cpu_ready, host_ack, cpu_clk_en};

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- DUT ----------------
   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .HOST_MAX_STREAK(4)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_clk_en(cpu_clk_en),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_rdata(host_rdata), .host_ack(host_ack),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .dbg_state(dbg_state), .dbg_streak(dbg_streak)
`ifdef ARB_STATS_EN
      ,
      .stat_cpu_grants(stat_cpu_grants), .stat_host_grants(stat_host_grants),
      .stat_cpu_stall_cycles(stat_cpu_stall_cycles)
`endif
   );

   // ---------------- memory model ----------------
   logic [DATA_W-1:0] mem_arr [0:255];
   logic              pre_en = 1'b0;
   logic [7:0]        pre_idx = '0;
   logic [DATA_W-1:0] pre_data = '0;

   always @(posedge clk) begin
      if (pre_en)
         mem_arr[pre_idx] <= pre_data;
      else if (mem_en) begin
         if (mem_we) mem_arr[mem_addr[9:2]] <= mem_wdata;
         else        mem_rdata <= mem_arr[mem_addr[9:2]];
      end
   end

   // ---------------- driver tasks ----------------
   task automatic preload(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
      @(negedge clk);
      pre_en   = 1'b1;
      pre_idx  = addr[9:2];
      pre_data = data;
      @(negedge clk);
      pre_en   = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      checks++; if (ctrl !== 5'b00001) begin errors++; $display("FAIL reset_ctrl: got %b expected %b", ctrl, 5'b00001); end
      checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_bus: got addr %h wdata %h expected 0", mem_addr, mem_wdata); end
      checks++; if (cpu_rdata !== 32'h0 || host_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got cpu %h host %h expected 0", cpu_rdata, host_rdata); end
      checks++; if (dbg_state !== 2'd0 || dbg_streak !== 4'd0) begin errors++; $display("FAIL reset_state: got state %0d streak %0d expected 0 0", dbg_state, dbg_streak); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_cpu_read();
      preload(32'h10, 32'hDEADBEEF);
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_wdata = '0;
      #1;
      checks++; if (ctrl !== 5'b10000) begin errors++; $display("FAIL cpu_read_grant: got %b expected %b", ctrl, 5'b10000); end
      checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL cpu_read_addr: got %h expected %h", mem_addr, 32'h10); end
      @(negedge clk); #1;
      checks++; if (ctrl !== 5'b00101) begin errors++; $display("FAIL cpu_read_rsp: got %b expected %b", ctrl, 5'b00101); end
      checks++; if (cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL cpu_read_data: got %h expected %h", cpu_rdata, 32'hDEADBEEF); end
      checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL cpu_read_state: got %0d expected 1", dbg_state); end
      cpu_req = 1'b0;
      @(negedge clk); #1;
      checks++; if (ctrl !== 5'b00001) begin errors++; $display("FAIL cpu_read_after: got %b expected %b", ctrl, 5'b00001); end
      checks++; if (cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL cpu_read_hold: got %h expected %h", cpu_rdata, 32'hDEADBEEF); end
   endtask

   task automatic test_host_write_cpu_read();
      @(negedge clk);
      host_req = 1'b1; host_we = 1'b1; host_addr = 32'h20; host_wdata = 32'h1234;
      cpu_req  = 1'b1; cpu_we  = 1'b0; cpu_addr  = 32'h20;
      #1;
      checks++; if (ctrl !== 5'b11000) begin errors++; $display("FAIL hw_grant: got %b expected %b", ctrl, 5'b11000); end
      checks++; if (mem_addr !== 32'h20 || mem_wdata !== 32'h1234) begin errors++; $display("FAIL hw_bus: got %h/%h expected 20/1234", mem_addr, mem_wdata); end
      @(negedge clk);
      host_wdata = 32'hFFFFFFFF;
      #1;
      checks++; if (ctrl !== 5'b00010) begin errors++; $display("FAIL hw_ack: got %b expected %b", ctrl, 5'b00010); end
      checks++; if (host_rdata !== 32'h0) begin errors++; $display("FAIL hw_rdata_hold: got %h expected 0", host_rdata); end
      checks++; if (dbg_streak !== 4'd1) begin errors++; $display("FAIL hw_streak: got %0d expected 1", dbg_streak); end
      host_req = 1'b0;
      @(negedge clk); #1;
      checks++; if (ctrl !== 5'b10000 || mem_addr !== 32'h20) begin errors++; $display("FAIL cr_grant: got %b addr %h expected %b addr 20", ctrl, mem_addr, 5'b10000); end
      @(negedge clk); #1;
      checks++; if (ctrl !== 5'b00101) begin errors++; $display("FAIL cr_rsp: got %b expected %b", ctrl, 5'b00101); end
      checks++; if (cpu_rdata !== 32'h1234) begin errors++; $display("FAIL cr_data: got %h expected %h", cpu_rdata, 32'h1234); end
      checks++; if (dbg_streak !== 4'd0) begin errors++; $display("FAIL cr_streak: got %0d expected 0", dbg_streak); end
      cpu_req = 1'b0;
   endtask

   task automatic test_cpu_write_host_read();
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'h55;
      #1;
      checks++; if (ctrl !== 5'b11000 || mem_wdata !== 32'h55) begin errors++; $display("FAIL cw_grant: got %b wdata %h expected %b wdata 55", ctrl, mem_wdata, 5'b11000); end
      @(negedge clk);
      cpu_wdata = 32'h0;
      #1;
      checks++; if (ctrl !== 5'b00101) begin errors++; $display("FAIL cw_rsp: got %b expected %b", ctrl, 5'b00101); end
      checks++; if (cpu_rdata !== 32'h1234) begin errors++; $display("FAIL cw_rdata_hold: got %h expected %h", cpu_rdata, 32'h1234); end
      cpu_req = 1'b0; cpu_we = 1'b0;
      host_req = 1'b1; host_we = 1'b0; host_addr = 32'h30;
      @(negedge clk); #1;
      checks++; if (ctrl !== 5'b10001 || mem_addr !== 32'h30) begin errors++; $display("FAIL hr_grant: got %b addr %h expected %b addr 30", ctrl, mem_addr, 5'b10001); end
      @(negedge clk); #1;
      checks++; if (ctrl !== 5'b00011) begin errors++; $display("FAIL hr_ack: got %b expected %b", ctrl, 5'b00011); end
      checks++; if (host_rdata !== 32'h55) begin errors++; $display("FAIL hr_data: got %h expected %h", host_rdata, 32'h55); end
      host_req = 1'b0;
   endtask

   task automatic test_idle();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         checks++; if (ctrl !== 5'b00001) begin errors++; $display("FAIL idle_ctrl cycle %0d: got %b expected %b", i, ctrl, 5'b00001); end
      end
   endtask

   task automatic test_reset_mid_access();
      // reset during HOST_RSP with a non-zero streak
      @(negedge clk);
      host_req = 1'b1; host_we = 1'b0; host_addr = 32'h10;
      cpu_req  = 1'b1; cpu_we  = 1'b0; cpu_addr  = 32'h10;
      @(negedge clk); #1;
      checks++; if (ctrl !== 5'b00010 || dbg_streak !== 4'd1) begin errors++; $display("FAIL rh_pre: got %b streak %0d expected %b streak 1", ctrl, dbg_streak, 5'b00010); end
      #1 rst = 1'b1;
      #1;
      checks++; if (ctrl !== 5'b00001) begin errors++; $display("FAIL rh_ctrl: got %b expected %b", ctrl, 5'b00001); end
      checks++; if (dbg_state !== 2'd0 || dbg_streak !== 4'd0) begin errors++; $display("FAIL rh_state: got %0d/%0d expected 0/0", dbg_state, dbg_streak); end
      @(negedge clk);
      host_req = 1'b0;
      rst = 1'b0;
      // reset during CPU_RSP
      #1;
      checks++; if (ctrl !== 5'b10000 || mem_addr !== 32'h10) begin errors++; $display("FAIL rc_grant: got %b addr %h expected %b addr 10", ctrl, mem_addr, 5'b10000); end
      @(negedge clk); #1;
      checks++; if (ctrl !== 5'b00101) begin errors++; $display("FAIL rc_pre: got %b expected %b", ctrl, 5'b00101); end
      #1 rst = 1'b1;
      #1;
      checks++; if (ctrl !== 5'b00001) begin errors++; $display("FAIL rc_ctrl: got %b expected %b", ctrl, 5'b00001); end
      checks++; if (dbg_state !== 2'd0 || dbg_streak !== 4'd0) begin errors++; $display("FAIL rc_state: got %0d/%0d expected 0/0", dbg_state, dbg_streak); end
      checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL rc_rdata: got %h expected 0", cpu_rdata); end
      @(negedge clk);
      cpu_req = 1'b0;
      rst = 1'b0;
      @(negedge clk); #1;
      checks++; if (ctrl !== 5'b00001) begin errors++; $display("FAIL rc_after: got %b expected %b", ctrl, 5'b00001); end
   endtask

   task automatic test_contention();
      // expected per-cycle events, bit c = cycle c
      logic [19:0] host_m = 20'h15455;  // host grants 0,2,4,6,10,12,14,16
      logic [19:0] cpu_m  = 20'h40100;  // cpu grants 8,18
      logic [19:0] rdy_m  = 20'h80200;  // cpu_ready 9,19
      logic [19:0] ack_m  = 20'h2A8AA;  // host_ack 1,3,5,7,11,13,15,17
      logic [4:0]  exp_ctrl;
      // fresh reset so the statistics start from zero
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      preload(32'h40, 32'hA5A50040);
      preload(32'h44, 32'h11110044);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (c == 0) begin
            host_req = 1'b1; host_we = 1'b0; host_addr = 32'h40;
            cpu_req  = 1'b1; cpu_we  = 1'b0; cpu_addr  = 32'h44;
         end
         #1;
         exp_ctrl = {host_m[c] | cpu_m[c], 1'b0, rdy_m[c], ack_m[c], rdy_m[c]};
         checks++; if (ctrl !== exp_ctrl) begin errors++; $display("FAIL cont_ctrl cycle %0d: got %b expected %b", c, ctrl, exp_ctrl); end
         if (host_m[c]) begin
            checks++; if (mem_addr !== 32'h40) begin errors++; $display("FAIL cont_host_addr cycle %0d: got %h expected 40", c, mem_addr); end
         end
         if (cpu_m[c]) begin
            checks++; if (mem_addr !== 32'h44) begin errors++; $display("FAIL cont_cpu_addr cycle %0d: got %h expected 44", c, mem_addr); end
         end
         if (c == 1) begin
            checks++; if (host_rdata !== 32'hA5A50040) begin errors++; $display("FAIL cont_host_data: got %h expected %h", host_rdata, 32'hA5A50040); end
         end
         if (c == 8) begin
            checks++; if (dbg_streak !== 4'd4) begin errors++; $display("FAIL cont_streak_sat: got %0d expected 4", dbg_streak); end
         end
         if (c == 9) begin
            checks++; if (cpu_rdata !== 32'h11110044) begin errors++; $display("FAIL cont_cpu_data: got %h expected %h", cpu_rdata, 32'h11110044); end
         end
         if (c == 19) begin
            host_req = 1'b0;
            cpu_req  = 1'b0;
         end
      end
      @(negedge clk); #1;
      checks++; if (ctrl !== 5'b00001) begin errors++; $display("FAIL cont_end: got %b expected %b", ctrl, 5'b00001); end
`ifdef ARB_STATS_EN
      checks++; if (stat_host_grants !== 32'd8) begin errors++; $display("FAIL stat_host: got %0d expected 8", stat_host_grants); end
      checks++; if (stat_cpu_grants !== 32'd2) begin errors++; $display("FAIL stat_cpu: got %0d expected 2", stat_cpu_grants); end
      checks++; if (stat_cpu_stall_cycles !== 32'd18) begin errors++; $display("FAIL stat_stall: got %0d expected 18", stat_cpu_stall_cycles); end
`endif
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_cpu_read();
      test_host_write_cpu_read();
      test_cpu_write_host_read();
      test_idle();
      test_reset_mid_access();
      test_contention();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
